// File: rtl/pcm_play_pkg.sv
// Shared types and constants for the PCM playback scheduler.
package pcm_play_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_PLAY,
        ST_UNDERRUN
    } play_state_e;

    localparam int DIV_DEF       = 128;
    localparam int MUTE_HOLD_DEF = 4;

    // Field positions inside the 32-bit stereo word
    localparam int L_MSB = 31;
    localparam int L_LSB = 16;
    localparam int R_MSB = 15;
    localparam int R_LSB = 0;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } stereo_t;

endpackage

// File: rtl/pcm_fs_timer.sv
// Free-running frame counter: produces the fs frame clock and the
// end-of-frame boundary strobe (fcnt == DIV-1).
module pcm_fs_timer #(
    parameter int DIV = 128
) (
    input  logic clk,
    input  logic reset,
    output logic pcm_fs,
    output logic boundary
);

    localparam int FW = $clog2(DIV);

    logic [FW-1:0] fcnt;

    // DIV is a power of two, so natural wrap gives DIV-1 -> 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) fcnt <= '0;
        else       fcnt <= fcnt + 1'b1;
    end

    assign boundary = (fcnt == FW'(DIV - 1));
    assign pcm_fs   = ~fcnt[FW-1];

endmodule

// File: rtl/pcm_play_scheduler.sv
// PCM playback scheduler: one-entry sample hold, frame-aligned output
// update and underrun muting. Define PCM_UNDERRUN_COUNT_EN to add the
// saturating underrun_count output.
module pcm_play_scheduler
    import pcm_play_pkg::*;
#(
    parameter int DIV       = DIV_DEF,
    parameter int MUTE_HOLD = MUTE_HOLD_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        play_en,
    input  logic [31:0] st_data,
    input  logic        st_valid,
    output logic        st_ready,
    output logic        pcm_fs,
    output logic [15:0] pcm_ldata,
    output logic [15:0] pcm_rdata,
    output logic        pcm_mute,
    output logic        underrun
`ifdef PCM_UNDERRUN_COUNT_EN
    ,
    output logic [15:0] underrun_count
`endif
);

    play_state_e state, state_nxt;
    stereo_t     hold_data;
    logic        hold_full;
    logic [7:0]  hold_cnt, cnt_nxt;
    logic        boundary, accept;
    logic        load, silence, start_ur, hold_clr;

    pcm_fs_timer #(.DIV(DIV)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .pcm_fs   (pcm_fs),
        .boundary (boundary)
    );

    // Ready is gated by reset so the port reads 0 while reset is held
    assign st_ready = play_en & ~hold_full & ~reset;
    assign accept   = st_valid & st_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = hold_cnt;
        load      = 1'b0;
        silence   = 1'b0;
        start_ur  = 1'b0;
        hold_clr  = 1'b0;
        if (!play_en) begin
            state_nxt = ST_IDLE;
            silence   = 1'b1;
            hold_clr  = 1'b1;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_PRIME;
                    silence   = 1'b1;
                    hold_clr  = 1'b1;
                end
                ST_PRIME: begin
                    if (boundary && hold_full) begin
                        state_nxt = ST_PLAY;
                        load      = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (boundary) begin
                        if (hold_full) begin
                            load = 1'b1;
                        end else begin
                            state_nxt = ST_UNDERRUN;
                            start_ur  = 1'b1;
                            silence   = 1'b1;
                            cnt_nxt   = 8'(MUTE_HOLD);
                        end
                    end
                end
                ST_UNDERRUN: begin
                    if (boundary) begin
                        if (hold_cnt == '0 && hold_full) begin
                            state_nxt = ST_PLAY;
                            load      = 1'b1;
                        end else if (hold_cnt != '0) begin
                            cnt_nxt = hold_cnt - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            hold_full <= 1'b0;
            hold_data <= '0;
            pcm_ldata <= '0;
            pcm_rdata <= '0;
            pcm_mute  <= 1'b1;
            underrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= cnt_nxt;
            underrun <= start_ur;
            // A fresh accept in the IDLE->PRIME cycle wins over the clear
            if (accept) begin
                hold_full   <= 1'b1;
                hold_data.l <= st_data[L_MSB:L_LSB];
                hold_data.r <= st_data[R_MSB:R_LSB];
            end else if (load || hold_clr) begin
                hold_full <= 1'b0;
            end
            if (silence) begin
                pcm_mute  <= 1'b1;
                pcm_ldata <= '0;
                pcm_rdata <= '0;
            end else if (load) begin
                pcm_mute  <= 1'b0;
                pcm_ldata <= hold_data.l;
                pcm_rdata <= hold_data.r;
            end
        end
    end

`ifdef PCM_UNDERRUN_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            underrun_count <= '0;
        else if (state == ST_IDLE && play_en)
            underrun_count <= '0;
        else if (start_ur && underrun_count != 16'hFFFF)
            underrun_count <= underrun_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_pcm_play_scheduler.sv
// Directed bench for pcm_play_scheduler with a sample scoreboard.
module tb_pcm_play_scheduler;

    localparam int DIV = 128;
    localparam int MH  = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        play_en = 1'b0;
    logic        st_valid = 1'b0;
    logic [31:0] st_data = '0;
    logic        st_ready, pcm_fs, pcm_mute, underrun;
    logic [15:0] pcm_ldata, pcm_rdata;
`ifdef PCM_UNDERRUN_COUNT_EN
    logic [15:0] underrun_count;
`endif

    always #5 clk = ~clk;

    pcm_play_scheduler #(.DIV(DIV), .MUTE_HOLD(MH)) dut (
        .clk       (clk),
        .reset     (reset),
        .play_en   (play_en),
        .st_data   (st_data),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .pcm_fs    (pcm_fs),
        .pcm_ldata (pcm_ldata),
        .pcm_rdata (pcm_rdata),
        .pcm_mute  (pcm_mute),
        .underrun  (underrun)
`ifdef PCM_UNDERRUN_COUNT_EN
        ,
        .underrun_count (underrun_count)
`endif
    );

    int          n_asrt = 0, n_fail = 0;
    int          cyc = 0, n_under = 0, n_tog = 0, last_tog = -1;
    int          feed_idx = 0, last_acc = -1, first_acc = 0, n0 = 0, base = 0;
    logic        prev_fs = 1'b1, fs_rise = 1'b0;
    logic [31:0] sb[$];
    logic [31:0] exp_word;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_asrt++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_fs"}, 32'(pcm_fs), 1);
        chk({tag, "_mute"}, 32'(pcm_mute), 1);
        chk({tag, "_data"}, {pcm_ldata, pcm_rdata}, 0);
        chk({tag, "_ready"}, 32'(st_ready), 0);
        chk({tag, "_ur"}, 32'(underrun), 0);
`ifdef PCM_UNDERRUN_COUNT_EN
        chk({tag, "_urcnt"}, 32'(underrun_count), 0);
`endif
    endtask

    // One clock: record accepts into the scoreboard, then check outputs
    task automatic tick();
        logic acc;
        @(negedge clk);
        acc = st_valid && st_ready;
        if (acc) begin
            sb.push_back(st_data);
            last_acc = cyc + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
        fs_rise = pcm_fs && !prev_fs;
        if (pcm_fs !== prev_fs) begin
            if (last_tog >= 0) chk("fs_half_period", 32'(cyc - last_tog), DIV / 2);
            last_tog = cyc;
            n_tog++;
        end
        prev_fs = pcm_fs;
        if (underrun) begin
            n_under++;
            chk("ur_pulse_muted", 32'(pcm_mute), 1);
        end
        if (pcm_mute) chk("mute_data_zero", {pcm_ldata, pcm_rdata}, 0);
        if (fs_rise && !pcm_mute) begin
            chk("sb_has_entry", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                exp_word = sb.pop_front();
                chk("sb_sample", {pcm_ldata, pcm_rdata}, exp_word);
            end
        end
        if (acc) begin
            feed_idx++;
            st_data = (feed_idx == 1) ? 32'h0001_FFFF : $urandom();
        end
    endtask

    task automatic wait_fs();
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < 2 * DIV + 4; i++) begin
            tick();
            if (fs_rise) begin
                ok = 1'b1;
                break;
            end
        end
        chk("fs_rise_seen", 32'(ok), 1);
    endtask

    task automatic induce_underrun();
        int u0, muted;
        wait_fs();
        st_valid = 1'b0;
        u0 = n_under;
        wait_fs();
        chk("ur_mute", 32'(pcm_mute), 1);
        chk("ur_pulse", 32'(n_under - u0), 1);
        st_valid = 1'b1;
        muted = 1;
        for (int i = 0; i < MH + 4; i++) begin
            wait_fs();
            if (!pcm_mute) break;
            muted++;
        end
        chk("ur_muted_frames", 32'(muted), MH + 1);
        chk("ur_single_pulse", 32'(n_under - u0), 1);
        chk("ur_resume", 32'(pcm_mute), 0);
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_reset_vals("reset");
        tick();
        reset = 1'b0;

        // Idle: frame clock runs, outputs silent
        repeat (300) begin
            tick();
            chk("idle_mute", 32'(pcm_mute), 1);
            chk("idle_data", {pcm_ldata, pcm_rdata}, 0);
            chk("idle_ready", 32'(st_ready), 0);
        end
        chk("idle_fs_toggles", 32'(n_tog >= 4), 1);

        // Prime and play two directed samples
        feed_idx = 0;
        st_data  = 32'h1234_ABCD;
        st_valid = 1'b1;
        play_en  = 1'b1;
        tick();
        chk("first_accept", 32'(last_acc == cyc), 1);
        first_acc = last_acc;
        wait_fs();
        chk("prime_unmute", 32'(pcm_mute), 0);
        chk("prime_sample", {pcm_ldata, pcm_rdata}, 32'h1234_ABCD);
        chk("prime_latency", 32'(cyc - first_acc <= DIV + 1), 1);
        wait_fs();
        chk("second_unmute", 32'(pcm_mute), 0);
        chk("second_sample", {pcm_ldata, pcm_rdata}, 32'h0001_FFFF);
        wait_fs();
        wait_fs();

        // Starve one frame
        induce_underrun();
        wait_fs();

        // Drop play_en mid-frame with the hold full
        repeat (30) tick();
        chk("held_ready_low", 32'(st_ready), 0);
        n0 = n_under;
        play_en = 1'b0;
        tick();
        sb.delete();
        chk("drop_mute", 32'(pcm_mute), 1);
        chk("drop_data", {pcm_ldata, pcm_rdata}, 0);
        chk("drop_ready", 32'(st_ready), 0);
        chk("drop_ur", 32'(underrun), 0);
        repeat (2 * DIV) tick();
        chk("drop_no_ur", 32'(n_under - n0), 0);
        chk("drop_still_mute", 32'(pcm_mute), 1);
        play_en = 1'b1;
        tick();
        chk("reen_accept", 32'(last_acc == cyc), 1);
        first_acc = last_acc;
        wait_fs();
        chk("reen_unmute", 32'(pcm_mute), 0);
        chk("reen_latency", 32'(cyc - first_acc <= DIV + 1), 1);

        // Reset mid-play
        wait_fs();
        repeat (20) tick();
        reset = 1'b1;
        #1;
        prev_fs  = 1'b1;
        last_tog = -1;
        sb.delete();
        chk_reset_vals("midrst");
        tick();
        chk_reset_vals("midrst_next");
        reset = 1'b0;
        wait_fs();
        chk("post_rst_unmute", 32'(pcm_mute), 0);

        // Three underruns in a row
        base = n_under;
        repeat (3) induce_underrun();
        chk("ur_total", 32'(n_under - base), 3);
`ifdef PCM_UNDERRUN_COUNT_EN
        chk("ur_count_port", 32'(underrun_count), 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
